// File: rtl/cic_pkg.sv
// Shared types, parameter limits and width helper for the CIC decimator.
package cic_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StRun} cic_state_e;

  localparam int unsigned OrderMin      = 1;
  localparam int unsigned OrderMax      = 5;
  localparam int unsigned Log2DecMin    = 2;
  localparam int unsigned Log2DecMax    = 10;

  // Bit growth of an ORDER-stage CIC at the largest ratio, plus sign and headroom.
  function automatic int unsigned cic_width(int unsigned order, int unsigned max_log2_dec);
    return order * max_log2_dec + 2;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section: delay register plus subtractor, y = x - x_delayed.
module cic_comb_stage #(
  parameter int unsigned W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] x_d_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x_d_q <= '0;
    end else if (en) begin
      x_d_q <= x;
    end
  end

  assign y = x - x_d_q;

endmodule

// File: rtl/cicn_decim.sv
// Runtime-selectable CIC decimator for a 1-bit modulator stream with
// normalised output and a valid/ready result register.
module cicn_decim
  import cic_pkg::*;
#(
  parameter int unsigned ORDER        = 3,
  parameter int unsigned MAX_LOG2_DEC = 8,
  parameter int unsigned W            = cic_width(ORDER, MAX_LOG2_DEC)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in,
  input  logic         in_valid,
  input  logic         enable,
  input  logic         bipolar,
  input  logic [3:0]   dec_sel,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun,
  output logic         busy
);

  localparam int unsigned CW = MAX_LOG2_DEC;
  localparam int unsigned FW = 3;

  cic_state_e    state_q, state_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic [3:0]    dec_sh_q;
  logic          bip_sh_q;
  logic [W-1:0]  acc_q [ORDER];
  logic [CW-1:0] cnt_q;
  logic          strobe_q;

  logic          clear, load, cfg_change, take;
  logic [3:0]    dec_eff, dec_gap;
  logic [7:0]    shamt;
  logic [CW-1:0] last_cnt;
  logic [W-1:0]  code;
  logic [W-1:0]  comb_x [ORDER+1];

  // Ratio decode; illegal selections fall back to the largest ratio.
  always_comb begin
    dec_eff = dec_sh_q;
    if (dec_sh_q < 4'd2 || dec_sh_q > 4'(MAX_LOG2_DEC)) begin
      dec_eff = 4'(MAX_LOG2_DEC);
    end
    dec_gap  = 4'(MAX_LOG2_DEC) - dec_eff;
    shamt    = 8'(ORDER) * {4'd0, dec_gap};
    last_cnt = {CW{1'b1}} >> dec_gap;
    code     = '0;
    if (in) begin
      code = W'(1);
    end else if (bip_sh_q) begin
      code = '1;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    clear      = 1'b0;
    load       = 1'b0;
    cfg_change = (dec_sel != dec_sh_q) || (bipolar != bip_sh_q);
    if (!enable) begin
      state_d = StIdle;
    end else if (state_q == StIdle || cfg_change) begin
      clear      = 1'b1;
      state_d    = StFill;
      fill_cnt_d = '0;
    end else if (strobe_q) begin
      case (state_q)
        StFill: begin
          if (fill_cnt_q == FW'(ORDER - 1)) begin
            state_d = StRun;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        StRun:   load = 1'b1;
        default: ;
      endcase
    end
  end

  assign take = strobe_q && (state_q != StIdle);
  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      dec_sh_q   <= '0;
      bip_sh_q   <= 1'b0;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      if (clear) begin
        dec_sh_q  <= dec_sel;
        bip_sh_q  <= bipolar;
        cnt_q     <= '0;
        strobe_q  <= 1'b0;
        for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
        out_data  <= '0;
        out_valid <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        strobe_q <= 1'b0;
        if (in_valid && enable && state_q != StIdle) begin
          // Each integrator adds the previous stage's pre-edge value.
          acc_q[0] <= acc_q[0] + code;
          for (int k = 1; k < ORDER; k++) acc_q[k] <= acc_q[k] + acc_q[k-1];
          if (cnt_q == last_cnt) begin
            cnt_q    <= '0;
            strobe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        if (load) begin
          out_data  <= comb_x[ORDER] << shamt;
          out_valid <= 1'b1;
          if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign comb_x[0] = acc_q[ORDER-1];

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .W(W)
    ) u_stage (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .en   (take),
      .x    (comb_x[k]),
      .y    (comb_x[k+1])
    );
  end

endmodule
